mux_nto1_scan: RTL and testbench
================================

Name: mux_nto1_scan

Overview:
Parametrised successor to the fixed 4-input, 1-bit selector.
- Selects one of NUM_CH channels, each DATA_W bits wide, into a registered output stage with a valid/ready handshake.
- Two modes: static (the host loads a select value) and scan (round-robin through channels with a programmable dwell, skipping channels whose valid is low).
- Sits between lab input sources and a downstream display or capture stage.

Parameters:
- NUM_CH, 4: number of input channels; must be at least 2.
- DATA_W, 8: bits per channel.
- DWELL, 4: accepted output captures per channel in scan mode before advancing; must be at least 1.
- SEL_W, derived as clog2(NUM_CH): channel index width. Localparam, not overridable.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- in_data  in  NUM_CH*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W].
- in_valid  in  NUM_CH  per-channel data valid.
- mode  in  1  0 = static, 1 = scan.
- sel  in  SEL_W  channel index to load.
- load_sel  in  1  one-cycle pulse: load sel into the current channel.
- out_data  out  DATA_W  registered selected data.
- out_valid  out  1  registered valid of the captured channel.
- out_ch  out  SEL_W  index of the captured channel.
- out_ready  in  1  downstream accepts when high.

Behaviour:
- Reset, synchronous, checked on the clock edge:
  - out_data = 0, out_valid = 0, out_ch = 0.
  - Internal cur_ch = 0, dwell counter cnt = 0.
  - Reset overrides all other inputs.
- accept = !out_valid || out_ready.
- On accept (single-cycle capture latency from cur_ch to the outputs):
  - out_data <= in_data[cur_ch]
  - out_valid <= in_valid[cur_ch]
  - out_ch <= cur_ch
- When !accept (stall): out_data, out_valid and out_ch hold; cnt holds.
- cur_ch/cnt update each edge, first matching rule wins:
  1. load_sel && sel < NUM_CH: cur_ch <= sel, cnt <= 0. Applies even during a stall.
  2. load_sel && sel >= NUM_CH: ignored; fall through to the next rules.
  3. mode changed since the previous cycle: cnt <= 0; cur_ch holds.
  4. mode=1 && accept && (cnt == DWELL-1 || !in_valid[cur_ch]):
     - cur_ch <= (cur_ch == NUM_CH-1) ? 0 : cur_ch+1
     - cnt <= 0
  5. mode=1 && accept: cnt <= cnt+1.
  6. Otherwise, including static mode: hold, with cnt = 0.
- Scan skip rule:
  - An invalid channel is still captured once (out_valid = 0), then left on the next accepted cycle.
  - If all channels are invalid, the block rotates one channel per accepted cycle and never hangs.
- Select timing: a load_sel on edge k is reflected in out_ch after edge k+1, provided accept holds at k+1.
- Width rules:
  - cnt is clog2(DWELL)+1 bits and never exceeds DWELL-1.
  - cur_ch never holds a value of NUM_CH or above.

Decomposition:
- Shared package mux_pkg holds:
  - the MODE_STATIC/MODE_SCAN encodings;
  - the clog2 constant function used to derive SEL_W and the counter width.
- One natural sub-module, channel_scanner: owns cur_ch, cnt and the previous-mode register, and implements update rules 1–6.
- The top level holds only the slice mux and the output register/handshake.

Test Plan:
Configuration for all cases unless stated: NUM_CH=4, DATA_W=8, DWELL=2, in_data = {8'h44, 8'h33, 8'h22, 8'h11}.
1. Reset: hold reset 2 cycles with in_valid = 4'hF and out_ready = 1 -> out_data = 0x00, out_valid = 0, out_ch = 0 throughout; first capture after release gives 0x11, ch 0.
2. Static select: mode = 0, all valid, out_ready = 1, load_sel pulse with sel = 2 -> after the second edge out_data = 0x33, out_ch = 2; output holds 0x33 indefinitely.
3. Scan: mode = 1, in_valid = 4'hF, out_ready = 1 -> out_ch sequence 0,0,1,1,2,2,3,3,0 with data 11,11,22,22,33,33,44,44,11.
4. Skip invalid: mode = 1, in_valid = 4'b1010 -> (ch, valid) pairs (0,0), (1,1), (1,1), (2,0), (3,1), (3,1), (0,0).
5. Backpressure: in scan, drop out_ready for 5 cycles once out_ch = 1 has been captured the first time -> out_data = 0x22 and out_ch = 1 stable for all 5 cycles; on release, ch 1 is captured exactly once more, then ch 2.
6. Out-of-range and reset mid-scan: build with NUM_CH = 5; load_sel with sel = 6 -> cur_ch unchanged. Then assert reset mid-dwell while stalled -> all outputs return to 0 next edge; scan restarts at ch 0 with a full dwell.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared definitions for the N-to-1 scanning selector: mode encodings and the
// constant-width helper used to size channel indices and the dwell counter.
package mux_pkg;

    typedef enum logic {
        MODE_STATIC = 1'b0,
        MODE_SCAN   = 1'b1
    } mode_e;

    // Ceiling log2 for elaboration-time sizing; clog2(1) is 0.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 32'sd0;
        rem    = value - 32'sd1;
        while (rem > 32'sd0) begin
            result = result + 32'sd1;
            rem    = rem >>> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/mux_nto1_scan_channel_scanner.sv
// Channel pointer and dwell counter: host select loads, mode-change restart,
// and round-robin advance that skips channels whose valid is low.
module channel_scanner
    import mux_pkg::*;
#(
    parameter int  NUM_CH = 4,
    parameter int  DWELL  = 4,
    localparam int SEL_W  = clog2(NUM_CH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             mode,
    input  logic [SEL_W-1:0] sel,
    input  logic             load_sel,
    input  logic [NUM_CH-1:0] in_valid,
    input  logic             accept,
    output logic [SEL_W-1:0] cur_ch
);

    localparam int               CNT_W    = clog2(DWELL) + 1;
    localparam logic [SEL_W:0]   NUM_CH_L = (SEL_W + 1)'(NUM_CH);
    localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(NUM_CH - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

    logic [SEL_W-1:0] cur_ch_r;
    logic [CNT_W-1:0] cnt_r;
    logic             prev_mode_r;

    logic             sel_ok_s;
    logic             mode_changed_s;
    logic             leave_ch_s;
    logic [SEL_W-1:0] next_ch_s;

    // Decode the conditions that drive the pointer update.
    always_comb begin
        sel_ok_s       = ({1'b0, sel} < NUM_CH_L);
        mode_changed_s = (mode != prev_mode_r);
        leave_ch_s     = (cnt_r == CNT_LAST) || !in_valid[cur_ch_r];
        if (cur_ch_r == LAST_CH) begin
            next_ch_s = '0;
        end else begin
            next_ch_s = cur_ch_r + SEL_W'(1);
        end
    end

    // Pointer/counter update; earlier branches take priority.
    always_ff @(posedge clock) begin
        // prev_mode tracks mode through reset so leaving reset is not a mode change
        prev_mode_r <= mode;
        if (reset) begin
            cur_ch_r <= '0;
            cnt_r    <= '0;
        end else if (load_sel && sel_ok_s) begin
            cur_ch_r <= sel;
            cnt_r    <= '0;
        end else if (mode_changed_s) begin
            cnt_r    <= '0;
        end else if ((mode == MODE_SCAN) && accept) begin
            if (leave_ch_s) begin
                cur_ch_r <= next_ch_s;
                cnt_r    <= '0;
            end else begin
                cnt_r    <= cnt_r + CNT_W'(1);
            end
        end else if (mode == MODE_STATIC) begin
            cnt_r    <= '0;
        end else begin
            cnt_r    <= cnt_r;
        end
    end

    assign cur_ch = cur_ch_r;

endmodule

// File: rtl/mux_nto1_scan.sv
// N-to-1 channel selector with static/scan modes feeding a registered
// valid/ready output stage.
module mux_nto1_scan
    import mux_pkg::*;
#(
    parameter int  NUM_CH = 4,
    parameter int  DATA_W = 8,
    parameter int  DWELL  = 4,
    localparam int SEL_W  = clog2(NUM_CH)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    input  logic [NUM_CH-1:0]        in_valid,
    input  logic                     mode,
    input  logic [SEL_W-1:0]         sel,
    input  logic                     load_sel,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_valid,
    output logic [SEL_W-1:0]         out_ch,
    input  logic                     out_ready
);

    logic [DATA_W-1:0] ch_data_s [NUM_CH];
    logic [SEL_W-1:0]  cur_ch_s;
    logic              accept_s;
    logic [DATA_W-1:0] sel_data_s;
    logic              sel_valid_s;

    logic [DATA_W-1:0] out_data_r;
    logic              out_valid_r;
    logic [SEL_W-1:0]  out_ch_r;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_slice
        assign ch_data_s[i] = in_data[i*DATA_W +: DATA_W];
    end

    channel_scanner #(
        .NUM_CH (NUM_CH),
        .DWELL  (DWELL)
    ) u_scanner (
        .clock    (clock),
        .reset    (reset),
        .mode     (mode),
        .sel      (sel),
        .load_sel (load_sel),
        .in_valid (in_valid),
        .accept   (accept_s),
        .cur_ch   (cur_ch_s)
    );

    // Handshake and slice selection for the current channel.
    always_comb begin
        accept_s    = !out_valid_r || out_ready;
        sel_data_s  = ch_data_s[cur_ch_s];
        sel_valid_s = in_valid[cur_ch_s];
    end

    // Output register: capture on accept, hold on stall.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_data_r  <= '0;
            out_valid_r <= 1'b0;
            out_ch_r    <= '0;
        end else if (accept_s) begin
            out_data_r  <= sel_data_s;
            out_valid_r <= sel_valid_s;
            out_ch_r    <= cur_ch_s;
        end else begin
            out_data_r  <= out_data_r;
            out_valid_r <= out_valid_r;
            out_ch_r    <= out_ch_r;
        end
    end

    assign out_data  = out_data_r;
    assign out_valid = out_valid_r;
    assign out_ch    = out_ch_r;

endmodule

// File: tb/tb_mux_nto1_scan.sv
// Bench for mux_nto1_scan: directed vector table, randomized run against a
// behavioural model, and an out-of-range / mid-scan reset sequence on NUM_CH=5.
module tb_mux_nto1_scan;

    localparam int DW = 2;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    // 4-channel instance
    logic        r4, m4, l4, rdy4;
    logic [31:0] d4;
    logic [3:0]  v4;
    logic [1:0]  s4;
    logic [7:0]  od4;
    logic        ov4;
    logic [1:0]  oc4;

    // 5-channel instance
    logic        r5, m5, l5, rdy5;
    logic [39:0] d5;
    logic [4:0]  v5;
    logic [2:0]  s5;
    logic [7:0]  od5;
    logic        ov5;
    logic [2:0]  oc5;

    mux_nto1_scan #(.NUM_CH(4), .DATA_W(8), .DWELL(DW)) dut4 (
        .clock(clock), .reset(r4), .in_data(d4), .in_valid(v4), .mode(m4),
        .sel(s4), .load_sel(l4), .out_data(od4), .out_valid(ov4),
        .out_ch(oc4), .out_ready(rdy4)
    );

    mux_nto1_scan #(.NUM_CH(5), .DATA_W(8), .DWELL(DW)) dut5 (
        .clock(clock), .reset(r5), .in_data(d5), .in_valid(v5), .mode(m5),
        .sel(s5), .load_sel(l5), .out_data(od5), .out_valid(ov5),
        .out_ch(oc5), .out_ready(rdy5)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic       rst;
        logic       mode;
        logic [3:0] valid;
        logic       ready;
        logic       load;
        logic [1:0] sel;
        logic [1:0] ch;
        logic       vld;
        logic [7:0] data;
    } vec_t;

    vec_t vecs[$];

    task automatic row(input logic rst, input logic mode, input logic [3:0] valid,
                       input logic ready, input logic load, input logic [1:0] sel,
                       input logic [1:0] ch, input logic vld, input logic [7:0] data);
        vec_t v;
        v.rst = rst; v.mode = mode; v.valid = valid; v.ready = ready;
        v.load = load; v.sel = sel; v.ch = ch; v.vld = vld; v.data = data;
        vecs.push_back(v);
    endtask

    // Behavioural model of the 4-channel instance
    logic [7:0] m_data;
    logic       m_valid;
    int         m_ch, m_cur, m_cnt;
    logic       m_prev;

    task automatic model_step();
        logic acc;
        logic [7:0] dsel;
        m_prev_upd: begin end
        if (r4) begin
            m_data = 8'h00; m_valid = 1'b0; m_ch = 0; m_cur = 0; m_cnt = 0;
        end else begin
            acc = !m_valid || rdy4;
            if (acc) begin
                dsel    = 8'((d4 >> (8 * m_cur)) & 32'hFF);
                m_data  = dsel;
                m_valid = v4[m_cur];
                m_ch    = m_cur;
            end
            if (l4 && (int'(s4) < 4)) begin
                m_cur = int'(s4); m_cnt = 0;
            end else if (m4 != m_prev) begin
                m_cnt = 0;
            end else if (m4 && acc) begin
                if ((m_cnt == DW - 1) || !v4[m_cur]) begin
                    m_cur = (m_cur + 1) % 4;
                    m_cnt = 0;
                end else begin
                    m_cnt = m_cnt + 1;
                end
            end
        end
        m_prev = m4;
    endtask

    task automatic t5(input logic rst, input logic mode, input logic ready,
                      input logic load, input logic [2:0] sel);
        r5 = rst; m5 = mode; rdy5 = ready; l5 = load; s5 = sel;
        @(posedge clock); #1;
    endtask

    initial begin
        r4 = 1'b1; m4 = 1'b0; l4 = 1'b0; rdy4 = 1'b1; s4 = 2'd0;
        d4 = 32'h44332211; v4 = 4'hF;
        r5 = 1'b1; m5 = 1'b0; l5 = 1'b0; rdy5 = 1'b1; s5 = 3'd0;
        d5 = 40'h5544332211; v5 = 5'h1F;

        // reset, then first capture
        row(1'b1, 1'b0, 4'hF, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 8'h00);
        row(1'b1, 1'b0, 4'hF, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 8'h00);
        row(1'b0, 1'b0, 4'hF, 1'b1, 1'b0, 2'd0, 2'd0, 1'b1, 8'h11);
        // static select of channel 2
        row(1'b0, 1'b0, 4'hF, 1'b1, 1'b1, 2'd2, 2'd0, 1'b1, 8'h11);
        row(1'b0, 1'b0, 4'hF, 1'b1, 1'b0, 2'd0, 2'd2, 1'b1, 8'h33);
        row(1'b0, 1'b0, 4'hF, 1'b1, 1'b0, 2'd0, 2'd2, 1'b1, 8'h33);
        row(1'b0, 1'b0, 4'hF, 1'b1, 1'b0, 2'd0, 2'd2, 1'b1, 8'h33);
        // scan, all valid
        row(1'b1, 1'b1, 4'hF, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 8'h00);
        for (int i = 0; i < 9; i++) begin
            logic [1:0] c;
            c = 2'((i / 2) % 4);
            row(1'b0, 1'b1, 4'hF, 1'b1, 1'b0, 2'd0, c, 1'b1, 8'(8'h11 * (c + 2'd1)));
        end
        // scan with skip of invalid channels 0 and 2
        row(1'b1, 1'b1, 4'b1010, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 8'h00);
        row(1'b0, 1'b1, 4'b1010, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 8'h11);
        row(1'b0, 1'b1, 4'b1010, 1'b1, 1'b0, 2'd0, 2'd1, 1'b1, 8'h22);
        row(1'b0, 1'b1, 4'b1010, 1'b1, 1'b0, 2'd0, 2'd1, 1'b1, 8'h22);
        row(1'b0, 1'b1, 4'b1010, 1'b1, 1'b0, 2'd0, 2'd2, 1'b0, 8'h33);
        row(1'b0, 1'b1, 4'b1010, 1'b1, 1'b0, 2'd0, 2'd3, 1'b1, 8'h44);
        row(1'b0, 1'b1, 4'b1010, 1'b1, 1'b0, 2'd0, 2'd3, 1'b1, 8'h44);
        row(1'b0, 1'b1, 4'b1010, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 8'h11);
        // backpressure on channel 1
        row(1'b1, 1'b1, 4'hF, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 8'h00);
        row(1'b0, 1'b1, 4'hF, 1'b1, 1'b0, 2'd0, 2'd0, 1'b1, 8'h11);
        row(1'b0, 1'b1, 4'hF, 1'b1, 1'b0, 2'd0, 2'd0, 1'b1, 8'h11);
        row(1'b0, 1'b1, 4'hF, 1'b1, 1'b0, 2'd0, 2'd1, 1'b1, 8'h22);
        for (int i = 0; i < 5; i++) begin
            row(1'b0, 1'b1, 4'hF, 1'b0, 1'b0, 2'd0, 2'd1, 1'b1, 8'h22);
        end
        row(1'b0, 1'b1, 4'hF, 1'b1, 1'b0, 2'd0, 2'd1, 1'b1, 8'h22);
        row(1'b0, 1'b1, 4'hF, 1'b1, 1'b0, 2'd0, 2'd2, 1'b1, 8'h33);

        foreach (vecs[k]) begin
            r4 = vecs[k].rst; m4 = vecs[k].mode; v4 = vecs[k].valid;
            rdy4 = vecs[k].ready; l4 = vecs[k].load; s4 = vecs[k].sel;
            @(posedge clock); #1;
            check($sformatf("vec%0d_ch", k),    32'(oc4), 32'(vecs[k].ch));
            check($sformatf("vec%0d_valid", k), 32'(ov4), 32'(vecs[k].vld));
            check($sformatf("vec%0d_data", k),  32'(od4), 32'(vecs[k].data));
        end

        // randomized run against the model
        m_prev = m4; m_data = 8'h00; m_valid = 1'b0; m_ch = 0; m_cur = 0; m_cnt = 0;
        for (int i = 0; i < 2000; i++) begin
            r4   = (i == 0) || ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 39) == 0) m4 = ~m4;
            if ($urandom_range(0, 7) == 0) v4 = 4'($urandom);
            rdy4 = ($urandom_range(0, 9) < 7);
            l4   = ($urandom_range(0, 24) == 0);
            s4   = 2'($urandom);
            d4   = $urandom;
            model_step();
            @(posedge clock); #1;
            check("rand_ch",    32'(oc4), 32'(m_ch));
            check("rand_valid", 32'(ov4), 32'(m_valid));
            check("rand_data",  32'(od4), 32'(m_data));
        end
        r4 = 1'b1;

        // NUM_CH=5: out-of-range select, then reset mid-dwell while stalled
        t5(1'b1, 1'b0, 1'b1, 1'b0, 3'd0);
        check("n5_reset_ch", 32'(oc5), 32'd0);
        t5(1'b0, 1'b0, 1'b1, 1'b1, 3'd3);
        t5(1'b0, 1'b0, 1'b1, 1'b0, 3'd0);
        check("n5_sel3_ch",   32'(oc5), 32'd3);
        check("n5_sel3_data", 32'(od5), 32'h44);
        t5(1'b0, 1'b0, 1'b1, 1'b1, 3'd6);
        t5(1'b0, 1'b0, 1'b1, 1'b0, 3'd0);
        check("n5_sel6_ignored", 32'(oc5), 32'd3);
        t5(1'b0, 1'b1, 1'b1, 1'b0, 3'd0);
        t5(1'b0, 1'b1, 1'b1, 1'b0, 3'd0);
        t5(1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
        check("n5_stall_ch", 32'(oc5), 32'd3);
        t5(1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
        check("n5_midreset_ch",    32'(oc5), 32'd0);
        check("n5_midreset_valid", 32'(ov5), 32'd0);
        check("n5_midreset_data",  32'(od5), 32'd0);
        t5(1'b0, 1'b1, 1'b1, 1'b0, 3'd0);
        check("n5_restart0_ch",   32'(oc5), 32'd0);
        check("n5_restart0_data", 32'(od5), 32'h11);
        t5(1'b0, 1'b1, 1'b1, 1'b0, 3'd0);
        check("n5_restart1_ch", 32'(oc5), 32'd0);
        t5(1'b0, 1'b1, 1'b1, 1'b0, 3'd0);
        check("n5_restart2_ch",   32'(oc5), 32'd1);
        check("n5_restart2_data", 32'(od5), 32'h22);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
